// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes a word bitstream LSB-first onto a ccff chain head.
// Optional readback parity check of the loaded chain: CCFF_READBACK_CHECK_EN.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              cfg_done,
  output logic              error
);
  localparam int TW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(WORD_W + 1);
  localparam logic [TW-1:0] LEN = TW'(CHAIN_LEN);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     total_q, total_d, tot_nxt;
  logic [WW-1:0]     wbits_q, wbits_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              head_q, head_d;
  logic              go, shift, last, hs, chk_last;
  int                rem;

  assign go      = start && (state_q == IDLE || state_q == DONE);
  assign shift   = (state_q == LOAD) && (wbits_q != '0);
  assign tot_nxt = total_q + TW'(shift);
  assign last    = shift && (tot_nxt == LEN);
  assign hs      = bs_valid && bs_ready;
  assign rem     = CHAIN_LEN - int'(tot_nxt);

`ifdef CCFF_READBACK_CHECK_EN
  localparam state_e POST = CHECK;
  logic par_q, par_d, err_q, err_d;

  assign chk_last = (state_q == CHECK) && (total_q == TW'(CHAIN_LEN - 1));

  // Loaded-bit parity and recirculated-tail parity share one accumulator.
  always_comb begin
    par_d = par_q;
    err_d = err_q;
    if (go) begin
      par_d = 1'b0;
      err_d = 1'b0;
    end else if (shift) begin
      par_d = par_q ^ sreg_q[0];
    end else if (state_q == CHECK) begin
      par_d = par_q ^ ccff_tail;
    end
    if (chk_last) err_d = par_d;
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      par_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      par_q <= par_d;
      err_q <= err_d;
    end
  end

  assign error = err_q;
`else
  localparam state_e POST = DONE;
  assign chk_last = 1'b0;
  assign error    = 1'b0;
`endif

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (go) state_d = LOAD;
      LOAD:       if (last) state_d = POST;
      CHECK:      if (chk_last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    bs_ready     = 1'b0;
    chain_clk_en = 1'b0;
    ccff_head    = head_q;
    busy         = (state_q == LOAD) || (state_q == CHECK);
    cfg_done     = (state_q == DONE);
    if (state_q == LOAD) begin
      bs_ready     = (wbits_q <= WW'(1)) && (tot_nxt < LEN);
      chain_clk_en = shift;
      if (shift) ccff_head = sreg_q[0];
    end
    if (state_q == CHECK) begin
      chain_clk_en = 1'b1;
      ccff_head    = ccff_tail;
    end
  end

  // A new word may land in the same cycle the previous word's last bit shifts.
  always_comb begin
    total_d = total_q;
    wbits_d = wbits_q;
    sreg_d  = sreg_q;
    head_d  = head_q;
    if (go) begin
      total_d = '0;
      wbits_d = '0;
    end
    if (shift) begin
      sreg_d  = sreg_q >> 1;
      wbits_d = wbits_q - WW'(1);
      total_d = tot_nxt;
      head_d  = sreg_q[0];
    end
    if (hs) begin
      sreg_d  = bs_data;
      wbits_d = (rem > WORD_W) ? WW'(WORD_W) : WW'(rem);
    end
    if (last && POST == CHECK) total_d = '0;
    if (state_q == CHECK) total_d = total_q + TW'(1);
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      total_q <= '0;
      wbits_q <= '0;
      sreg_q  <= '0;
      head_q  <= 1'b0;
    end else begin
      total_q <= total_d;
      wbits_q <= wbits_d;
      sreg_q  <= sreg_d;
      head_q  <= head_d;
    end
  end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: scoreboard bench with a chain model for ccff_chain_loader.
// Expected head bits come from the word list; a monitor pops and compares them.
module tb_ccff_chain_loader;
  localparam int L  = 20;
  localparam int W  = 8;
  localparam int NW = (L + W - 1) / W;
`ifdef CCFF_READBACK_CHECK_EN
  localparam int CHK = L;
`else
  localparam int CHK = 0;
`endif

  logic         prog_clk = 1'b0;
  logic         prog_reset = 1'b1;
  logic         start = 1'b0;
  logic         bs_valid = 1'b0;
  logic [W-1:0] bs_data = '0;
  logic         ccff_tail;
  logic         bs_ready, ccff_head, chain_clk_en, busy, cfg_done, error;

  int n_chk = 0;
  int n_fail = 0;
  bit exp_q[$];
  logic [W-1:0] words [NW];
  logic [L-1:0] chain = '0;
  int shifted = 0, chk_cyc = 0, done_evt = 0, done_cyc = 0;
  int hs_cyc = 0, cyc = 0;
  logic last_head = 1'b0, prev_en = 1'b0, prev_done = 1'b0;
  logic exp_err = 1'b0, flip = 1'b0;

  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
    .ccff_head(ccff_head), .chain_clk_en(chain_clk_en),
    .ccff_tail(ccff_tail), .busy(busy), .cfg_done(cfg_done),
    .error(error)
  );

  always #5 prog_clk = ~prog_clk;
  always @(posedge prog_clk) cyc <= cyc + 1;

  // Chain model; optionally corrupts one stored bit on the final load shift.
  always @(posedge prog_clk) begin
    logic [L-1:0] nxt;
    if (chain_clk_en) begin
      nxt = {chain[L-2:0], ccff_head};
      if (flip && shifted == L && chk_cyc == 0) nxt[3] = ~nxt[3];
      chain <= nxt;
    end
  end
  assign ccff_tail = chain[L-1];

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge prog_clk) begin
    bit e;
    if (!prog_reset) begin
      if (chain_clk_en && shifted < L) begin
        if (exp_q.size() == 0) begin
          check("extra_shift", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("head_bit", int'(ccff_head), int'(e));
        end
        last_head = ccff_head;
        shifted++;
      end else if (chain_clk_en) begin
        check("recirc", int'(ccff_head), int'(ccff_tail));
        chk_cyc++;
      end else if (busy && shifted > 0) begin
        check("head_hold", int'(ccff_head), int'(last_head));
      end
      if (cfg_done && !prev_done) begin
        check("done_bits", shifted, L);
        check("done_chk_cycles", chk_cyc, CHK);
        check("done_after_shift", int'(prev_en), 1);
        check("done_error", int'(error), int'(exp_err));
        check("done_queue_empty", exp_q.size(), 0);
        done_cyc = cyc;
        done_evt++;
      end
      prev_en = chain_clk_en;
      prev_done = cfg_done;
    end
  end

  // mode 0: back-to-back, 1: 3 stall cycles between words, 2: random valid/start
  task automatic run_load(input int mode, input int abort_at, input int exp_lat);
    int k, t, idle, d0;
    logic [W-1:0] w;
    d0 = done_evt;
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
    check("start_ack", int'({cfg_done, busy, error}), 2);
    shifted = 0;
    chk_cyc = 0;
    exp_q.delete();
    for (int i = 0; i < L; i++) begin
      w = words[i / W];
      exp_q.push_back(w[i % W]);
    end
    k = 0; t = 0; idle = 0;
    while (k < NW && t < 400) begin
      @(posedge prog_clk); #1;
      start = (mode == 2) && ($urandom_range(0, 7) == 0);
      bs_data = words[k];
      if (mode == 2) bs_valid = ($urandom_range(0, 2) != 0);
      else if (mode == 1) bs_valid = (k == 0) || (idle >= 3);
      else bs_valid = 1'b1;
      @(negedge prog_clk); #1;
      t++;
      if (abort_at > 0 && shifted >= abort_at) begin
        prog_reset = 1'b1;
        #1;
        check("reset_outputs",
          int'({bs_ready, ccff_head, chain_clk_en, busy, cfg_done, error}), 0);
        bs_valid = 1'b0;
        start = 1'b0;
        exp_q.delete();
        shifted = 0;
        @(negedge prog_clk); #2 prog_reset = 1'b0;
        repeat (2) @(negedge prog_clk);
        check("post_reset_idle", int'({busy, cfg_done, bs_ready}), 0);
        return;
      end
      if (bs_valid && bs_ready) begin
        if (k == 0) hs_cyc = cyc;
        k++;
        idle = 0;
      end else if (bs_ready) begin
        idle++;
      end
    end
    if (k < NW) check("handshake_timeout", k, NW);
    @(posedge prog_clk); #1;
    bs_valid = 1'b0;
    start = 1'b0;
    t = 0;
    while (done_evt == d0 && t < 200) begin
      @(negedge prog_clk); #1;
      t++;
    end
    check("done_seen", int'(done_evt != d0), 1);
    if (exp_lat > 0) check("done_latency", done_cyc - hs_cyc, exp_lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge prog_clk);
    check("reset_state",
      int'({bs_ready, ccff_head, chain_clk_en, busy, cfg_done, error}), 0);
    repeat (2) @(negedge prog_clk);
    prog_reset = 1'b0;
    bs_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bs_data = W'($urandom);
      @(negedge prog_clk); #1;
      check("idle_ignores_valid", int'({bs_ready, busy, chain_clk_en}), 0);
    end
    bs_valid = 1'b0;

    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    run_load(0, 0, L + 1 + CHK);
    run_load(1, 0, L + 1 + 6 + CHK);

    for (int i = 0; i < NW; i++) words[i] = W'($urandom);
    run_load(0, 9, 0);
    run_load(2, 0, 0);

    for (int i = 0; i < NW; i++) words[i] = '0;
    run_load(0, 0, L + 1 + CHK);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NW; i++) words[i] = W'($urandom);
      run_load(2, 0, 0);
    end

    words[0] = 8'h96; words[1] = 8'h5A; words[2] = 8'h0C;
    flip = 1'b1;
    exp_err = (CHK > 0);
    run_load(0, 0, L + 1 + CHK);
    flip = 1'b0;
    exp_err = 1'b0;
    run_load(2, 0, 0);

    repeat (3) @(negedge prog_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
